// File: rtl/seq_match_monitor.sv
// seq_match_monitor: statistics on the MATCH pulse from the "10101011"
// detector. It keeps a saturating match count, the distance between the last
// two matches, the smallest distance seen, a sticky flag for spacings the
// pattern cannot legally produce, and a pulse when matches cluster in a burst.
module seq_match_monitor #(
  parameter int CNT_W         = 16,
  parameter int GAP_W         = 8,
  parameter int MIN_LEGAL_GAP = 7,
  parameter int BURST_GAP     = 8,
  parameter int BURST_N       = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             MATCH,
  output logic [CNT_W-1:0] MATCH_CNT,
  output logic             CNT_SAT,
  output logic [GAP_W-1:0] LAST_GAP,
  output logic [GAP_W-1:0] MIN_GAP,
  output logic             GAP_VALID,
  output logic             GAP_ERR,
  output logic             BURST
);

  localparam int RUN_W = $clog2(BURST_N + 1);
  localparam logic [GAP_W-1:0] GAP_MAX   = '1;
  localparam logic [GAP_W-1:0] GAP_LEGAL = GAP_W'(MIN_LEGAL_GAP);
  localparam logic [GAP_W-1:0] GAP_CLOSE = GAP_W'(BURST_GAP);
  localparam logic [RUN_W-1:0] RUN_FIRE  = RUN_W'(BURST_N);

  typedef enum logic {S_IDLE = 1'b0, S_TRACK = 1'b1} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_match_cnt;
  logic             r_cnt_sat;
  logic [GAP_W-1:0] r_last_gap;
  logic [GAP_W-1:0] r_min_gap;
  logic             r_gap_valid;
  logic             r_gap_err;
  logic             r_burst;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [RUN_W-1:0] r_run_cnt;

  logic [CNT_W-1:0] w_cnt_next;
  logic [RUN_W-1:0] w_run_inc;

  // Saturating increments used when a match is accepted.
  always_comb begin
    w_cnt_next = (r_match_cnt == '1) ? r_match_cnt : r_match_cnt + CNT_W'(1);
    w_run_inc  = r_run_cnt + RUN_W'(1);
  end

  // Tracking FSM: the gap counter holds the distance, in edges, since the
  // previous accepted match; all statistics update on the edge a match is seen.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_match_cnt <= '0;
      r_cnt_sat   <= 1'b0;
      r_last_gap  <= '0;
      r_min_gap   <= '1;
      r_gap_valid <= 1'b0;
      r_gap_err   <= 1'b0;
      r_burst     <= 1'b0;
      r_gap_cnt   <= '0;
      r_run_cnt   <= '0;
    end else if (CLR) begin
      // Clear wins over a coincident MATCH, which is simply dropped.
      r_state     <= S_IDLE;
      r_match_cnt <= '0;
      r_cnt_sat   <= 1'b0;
      r_last_gap  <= '0;
      r_min_gap   <= '1;
      r_gap_valid <= 1'b0;
      r_gap_err   <= 1'b0;
      r_burst     <= 1'b0;
      r_gap_cnt   <= '0;
      r_run_cnt   <= '0;
    end else begin
      r_burst <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (MATCH) begin
            r_state     <= S_TRACK;
            r_match_cnt <= w_cnt_next;
            if (w_cnt_next == '1) r_cnt_sat <= 1'b1;
            r_gap_cnt   <= GAP_W'(1);
            r_run_cnt   <= RUN_W'(1);
          end
        end
        S_TRACK: begin
          if (MATCH) begin
            r_last_gap  <= r_gap_cnt;
            r_gap_cnt   <= GAP_W'(1);
            r_gap_valid <= 1'b1;
            r_match_cnt <= w_cnt_next;
            if (w_cnt_next == '1) r_cnt_sat <= 1'b1;
            if (r_gap_cnt < r_min_gap) r_min_gap <= r_gap_cnt;
            if (r_gap_cnt < GAP_LEGAL) r_gap_err <= 1'b1;
            // A close match extends the run; reaching the threshold fires
            // the pulse and restarts the run at this match.
            if (r_gap_cnt <= GAP_CLOSE) begin
              if (w_run_inc == RUN_FIRE) begin
                r_burst   <= 1'b1;
                r_run_cnt <= RUN_W'(1);
              end else begin
                r_run_cnt <= w_run_inc;
              end
            end else begin
              r_run_cnt <= RUN_W'(1);
            end
          end else if (r_gap_cnt != GAP_MAX) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign MATCH_CNT = r_match_cnt;
  assign CNT_SAT   = r_cnt_sat;
  assign LAST_GAP  = r_last_gap;
  assign MIN_GAP   = r_min_gap;
  assign GAP_VALID = r_gap_valid;
  assign GAP_ERR   = r_gap_err;
  assign BURST     = r_burst;

endmodule

// File: tb/tb_seq_match_monitor.sv
// Bench for seq_match_monitor: two instances (default counter width and a
// 4-bit counter) share stimulus; a list-of-match-times model is compared on
// every falling edge, and directed scenarios add literal expectations.
module tb_seq_match_monitor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CLR;
  logic        MATCH;

  logic [15:0] cnt_a;
  logic        sat_a;
  logic [7:0]  last_a;
  logic [7:0]  min_a;
  logic        valid_a;
  logic        err_a;
  logic        burst_a;

  logic [3:0]  cnt_b;
  logic        sat_b;
  logic [7:0]  last_b;
  logic [7:0]  min_b;
  logic        valid_b;
  logic        err_b;
  logic        burst_b;

  int errors = 0;
  int checks = 0;

  seq_match_monitor dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .MATCH(MATCH),
    .MATCH_CNT(cnt_a), .CNT_SAT(sat_a), .LAST_GAP(last_a), .MIN_GAP(min_a),
    .GAP_VALID(valid_a), .GAP_ERR(err_a), .BURST(burst_a)
  );

  seq_match_monitor #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .MATCH(MATCH),
    .MATCH_CNT(cnt_b), .CNT_SAT(sat_b), .LAST_GAP(last_b), .MIN_GAP(min_b),
    .GAP_VALID(valid_b), .GAP_ERR(err_b), .BURST(burst_b)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT on each rising edge.
  logic s_match, s_clr;
  always @(posedge CLK) begin
    s_match <= MATCH;
    s_clr   <= CLR;
  end

  // Model: match times since the last reset/clear, reduced to gap statistics.
  int n, cyc, last_t, m_last, m_min, close_run;
  bit m_err, m_burst;

  task automatic model_reset();
    n = 0; last_t = 0; m_last = 0; m_min = 255; close_run = 0;
    m_err = 0; m_burst = 0;
  endtask

  task automatic model_step();
    int diff, g;
    m_burst = 0;
    if (s_clr) begin
      model_reset();
    end else if (s_match) begin
      if (n == 0) begin
        n = 1;
        close_run = 0;
      end else begin
        diff = cyc - last_t;
        g = (diff > 255) ? 255 : diff;
        m_last = g;
        if (g < m_min) m_min = g;
        if (g < 7) m_err = 1;
        n++;
        // Every second consecutive close gap completes a run of three matches.
        if (g <= 8) begin
          close_run++;
          m_burst = (close_run % 2) == 0;
        end else begin
          close_run = 0;
        end
      end
      last_t = cyc;
    end
    cyc++;
  endtask

  // Every-cycle comparison of both instances against the model.
  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(negedge CLK);
      if (!RST) model_reset();
      else model_step();
      chk("a.cnt",   cnt_a,   (n > 65535) ? 65535 : n);
      chk("a.sat",   sat_a,   n >= 65535);
      chk("b.cnt",   cnt_b,   (n > 15) ? 15 : n);
      chk("b.sat",   sat_b,   n >= 15);
      chk("a.last",  last_a,  m_last);
      chk("b.last",  last_b,  m_last);
      chk("a.min",   min_a,   m_min);
      chk("b.min",   min_b,   m_min);
      chk("a.valid", valid_a, n >= 2);
      chk("b.valid", valid_b, n >= 2);
      chk("a.err",   err_a,   m_err);
      chk("b.err",   err_b,   m_err);
      chk("a.burst", burst_a, m_burst);
      chk("b.burst", burst_b, m_burst);
    end
  end

  // One edge of stimulus: inputs change on the falling edge.
  task automatic step(input bit m, input bit c);
    @(negedge CLK);
    MATCH = m;
    CLR   = c;
  endtask

  // Next match g edges after the previous one.
  task automatic gap(input int g);
    repeat (g - 1) step(0, 0);
    step(1, 0);
  endtask

  initial begin
    RST = 1'b0; CLR = 1'b0; MATCH = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;

    // Idle after reset
    repeat (20) step(0, 0);
    chk("idle.cnt", cnt_a, 0);
    chk("idle.valid", valid_a, 0);
    chk("idle.min", min_a, 8'hFF);
    chk("idle.flags", {sat_a, err_a, burst_a}, 0);
    $display("txn idle: cnt=%0d min=%0d", cnt_a, min_a);

    // Matches at 10, 17, 27
    repeat (10) step(0, 0);
    step(1, 0); gap(7); gap(10); step(0, 0);
    chk("three.cnt", cnt_a, 3);
    chk("three.last", last_a, 10);
    chk("three.min", min_a, 7);
    chk("three.err", err_a, 0);
    chk("three.valid", valid_a, 1);
    $display("txn three: cnt=%0d last=%0d min=%0d", cnt_a, last_a, min_a);

    // Illegal gap of 3, sticky until clear
    step(0, 1);
    repeat (5) step(0, 0);
    step(1, 0); gap(3); step(0, 0);
    chk("short.last", last_a, 3);
    chk("short.err", err_a, 1);
    gap(9); gap(9); step(0, 0);
    chk("sticky.err", err_a, 1);
    chk("sticky.last", last_a, 9);
    chk("sticky.min", min_a, 3);
    step(0, 1); step(0, 0);
    chk("clr.err", err_a, 0);
    chk("clr.cnt", cnt_a, 0);
    chk("clr.min", min_a, 8'hFF);
    $display("txn short-gap: err cleared=%0d", !err_a);

    // Burst at the third close match, then long silence saturates the gap
    step(1, 0); gap(7); gap(7); step(0, 0);
    chk("burst.pulse", burst_a, 1);
    chk("burst.cnt", cnt_a, 3);
    step(0, 0);
    chk("burst.single", burst_a, 0);
    gap(301); step(0, 0);
    chk("sat.last", last_a, 255);
    chk("sat.burst", burst_a, 0);
    chk("sat.min", min_a, 7);
    $display("txn burst: last=%0d", last_a);

    // Back-to-back matches: gap 1, burst after two close gaps
    gap(1); gap(1); step(0, 0);
    chk("b2b.last", last_a, 1);
    chk("b2b.burst", burst_a, 1);
    chk("b2b.err", err_a, 1);
    $display("txn back-to-back: last=%0d min=%0d", last_a, min_a);

    // CLR and MATCH together: MATCH dropped
    step(1, 1); step(0, 0);
    chk("clrm.cnt", cnt_a, 0);
    chk("clrm.last", last_a, 0);
    chk("clrm.min", min_a, 8'hFF);
    chk("clrm.valid", valid_a, 0);
    chk("clrm.err", err_a, 0);
    step(1, 0); step(0, 0);
    chk("clrm.next_cnt", cnt_a, 1);
    chk("clrm.next_valid", valid_a, 0);
    $display("txn clr+match: cnt=%0d", cnt_a);

    // 17 matches 8 apart: 4-bit counter saturates
    step(0, 1);
    step(1, 0);
    repeat (16) gap(8);
    step(0, 0);
    chk("w4.cnt", cnt_b, 15);
    chk("w4.sat", sat_b, 1);
    chk("w4.last", last_b, 8);
    chk("w16.cnt", cnt_a, 17);
    chk("w16.sat", sat_a, 0);
    $display("txn cnt-sat: cnt4=%0d cnt16=%0d", cnt_b, cnt_a);

    // Asynchronous reset mid-stream, between clock edges
    repeat (3) step(0, 0);
    #2 RST = 1'b0;
    #1;
    chk("arst.cnt4", cnt_b, 0);
    chk("arst.sat4", sat_b, 0);
    chk("arst.cnt", cnt_a, 0);
    chk("arst.last", last_a, 0);
    chk("arst.min", min_a, 8'hFF);
    chk("arst.valid", valid_a, 0);
    @(negedge CLK);
    #2 RST = 1'b1;
    repeat (4) step(0, 0);
    step(1, 0); step(0, 0);
    chk("arst.first_cnt", cnt_a, 1);
    chk("arst.first_valid", valid_a, 0);
    $display("txn async-reset: cnt=%0d", cnt_a);

    step(0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
